// File: rtl/calc_lexer.sv
// Stream calculator front end: parses ASCII literals/operators into queue commands.
// Optional CALC_DIV_EN builds the '/' and '%' datapath; otherwise those chars are illegal.
module calc_lexer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   ch,
  input  logic         ch_valid,
  output logic         ch_ready,
  input  logic [W-1:0] q_first,
  input  logic [W-1:0] q_second,
  input  logic         q_valid,
  output logic         q_apply,
  output logic [2:0]   q_op,
  output logic [W-1:0] q_in,
  output logic         err,
  output logic [1:0]   err_code
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_NUM    = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_ERR    = 3'd4;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MUL  = 3'd2;
  localparam logic [2:0] OP_DIV  = 3'd3;
  localparam logic [2:0] OP_MOD  = 3'd4;
  localparam logic [2:0] OP_PUSH = 3'd5;
  localparam logic [2:0] OP_DROP = 3'd6;

  logic [2:0]   state_q, state_d;
  logic [W-1:0] acc_q, acc_d;
  logic         pend_vld_q, pend_vld_d;
  logic [2:0]   pend_op_q, pend_op_d;
  logic         q_apply_q, q_apply_d;
  logic [2:0]   q_op_q, q_op_d;
  logic [W-1:0] q_in_q, q_in_d;
  logic         err_q, err_d;
  logic [1:0]   err_code_q, err_code_d;

  logic         is_digit, is_sep, is_op, accept, div0;
  logic [3:0]   digit;
  logic [2:0]   ch_op, issue_op;
  logic [W+3:0] acc_next;
  logic [W-1:0] alu_res;

  function automatic logic [W-1:0] alu(input logic [2:0] op, input logic [W-1:0] a,
                                       input logic [W-1:0] b);
    alu = '0;
    case (op)
      OP_ADD: alu = a + b;
      OP_SUB: alu = a - b;
      OP_MUL: alu = a * b;
`ifdef CALC_DIV_EN
      OP_DIV: alu = (b == '0) ? '0 : a / b;
      OP_MOD: alu = (b == '0) ? '0 : a % b;
`endif
      default: alu = '0;
    endcase
  endfunction

  always_comb begin
    is_digit = (ch >= 8'h30) && (ch <= 8'h39);
    is_sep   = (ch == 8'h20) || (ch == 8'h0a);
    digit    = ch[3:0];
    is_op    = 1'b1;
    ch_op    = OP_ADD;
    case (ch)
      8'h2b: ch_op = OP_ADD;
      8'h2d: ch_op = OP_SUB;
      8'h2a: ch_op = OP_MUL;
`ifdef CALC_DIV_EN
      8'h2f: ch_op = OP_DIV;
      8'h25: ch_op = OP_MOD;
`endif
      8'h64: ch_op = OP_DROP;
      default: is_op = 1'b0;
    endcase
  end

  // SETTLE issues the operator held back behind a push; otherwise it comes straight from ch.
  always_comb begin
    issue_op = (state_q == S_SETTLE) ? pend_op_q : ch_op;
    alu_res  = alu(issue_op, q_first, q_second);
    div0     = 1'b0;
`ifdef CALC_DIV_EN
    div0     = ((issue_op == OP_DIV) || (issue_op == OP_MOD)) && (q_second == '0);
`endif
    acc_next = (W+4)'(acc_q) * (W+4)'(10) + (W+4)'(digit);
  end

  assign ch_ready = (state_q == S_IDLE) || (state_q == S_NUM) || (state_q == S_ERR);
  assign accept   = ch_valid && ch_ready;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    pend_vld_d = pend_vld_q;
    pend_op_d  = pend_op_q;
    q_apply_d  = 1'b0;
    q_op_d     = q_op_q;
    q_in_d     = q_in_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    case (state_q)
      S_IDLE, S_NUM: begin
        if (accept) begin
          if (is_digit) begin
            if (state_q == S_IDLE) begin
              acc_d   = W'(digit);
              state_d = S_NUM;
            end else if (acc_next[W+3:W] != '0) begin
              state_d    = S_ERR;
              err_d      = 1'b1;
              err_code_d = 2'd2;
            end else begin
              acc_d = acc_next[W-1:0];
            end
          end else if (is_sep || is_op) begin
            if (state_q == S_NUM) begin
              q_apply_d  = 1'b1;
              q_op_d     = OP_PUSH;
              q_in_d     = acc_q;
              pend_vld_d = is_op;
              pend_op_d  = ch_op;
              state_d    = S_ISSUE;
            end else if (is_op) begin
              if (div0) begin
                state_d    = S_ERR;
                err_d      = 1'b1;
                err_code_d = 2'd2;
              end else begin
                q_apply_d = 1'b1;
                q_op_d    = ch_op;
                q_in_d    = alu_res;
                state_d   = S_ISSUE;
              end
            end
          end else begin
            state_d    = S_ERR;
            err_d      = 1'b1;
            err_code_d = 2'd1;
          end
        end
      end
      S_ISSUE: state_d = S_SETTLE;
      S_SETTLE: begin
        if (!q_valid) begin
          state_d    = S_ERR;
          err_d      = 1'b1;
          err_code_d = 2'd3;
        end else if (pend_vld_q) begin
          pend_vld_d = 1'b0;
          if (div0) begin
            state_d    = S_ERR;
            err_d      = 1'b1;
            err_code_d = 2'd2;
          end else begin
            q_apply_d = 1'b1;
            q_op_d    = pend_op_q;
            q_in_d    = alu_res;
            state_d   = S_ISSUE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      pend_vld_q <= 1'b0;
      pend_op_q  <= OP_ADD;
      q_apply_q  <= 1'b0;
      q_op_q     <= 3'd0;
      q_in_q     <= '0;
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      pend_vld_q <= pend_vld_d;
      pend_op_q  <= pend_op_d;
      q_apply_q  <= q_apply_d;
      q_op_q     <= q_op_d;
      q_in_q     <= q_in_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign q_apply  = q_apply_q;
  assign q_op     = q_op_q;
  assign q_in     = q_in_q;
  assign err      = err_q;
  assign err_code = err_code_q;

endmodule

// File: tb/tb_calc_lexer.sv
// Bench for calc_lexer: attached 8-deep operand queue, directed table, timing/reset sequences, random strings.
module tb_calc_lexer;
  localparam int W = 8;
  localparam int QDEPTH = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [7:0]   ch = 8'h00;
  logic         ch_valid = 1'b0;
  logic         ch_ready;
  logic [W-1:0] q_first, q_second;
  logic         q_valid;
  logic         q_apply;
  logic [2:0]   q_op;
  logic [W-1:0] q_in;
  logic         err;
  logic [1:0]   err_code;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  calc_lexer #(.W(W)) dut (
    .clk(clk), .rst(rst), .ch(ch), .ch_valid(ch_valid), .ch_ready(ch_ready),
    .q_first(q_first), .q_second(q_second), .q_valid(q_valid),
    .q_apply(q_apply), .q_op(q_op), .q_in(q_in), .err(err), .err_code(err_code)
  );

  // Attached queue: head-first FIFO; arithmetic pops two and puts the result at the head.
  int eq[$];
  int got_op[$];
  int got_in[$];
  bit env_ok;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      eq.delete();
      q_first  <= '0;
      q_second <= '0;
      q_valid  <= 1'b1;
    end else if (q_apply) begin
      got_op.push_back(int'(q_op));
      got_in.push_back(int'(q_in));
      env_ok = 1'b1;
      if (q_op == 3'd5) begin
        if (eq.size() >= QDEPTH) env_ok = 1'b0;
        else eq.push_back(int'(q_in));
      end else if (q_op <= 3'd4) begin
        if (eq.size() < 2) env_ok = 1'b0;
        else begin
          void'(eq.pop_front());
          void'(eq.pop_front());
          eq.push_front(int'(q_in));
        end
      end else if (q_op == 3'd6) begin
        if (eq.size() < 1) env_ok = 1'b0;
        else void'(eq.pop_front());
      end else begin
        env_ok = 1'b0;
      end
      q_valid  <= env_ok;
      q_first  <= (eq.size() > 0) ? W'(eq[0]) : '0;
      q_second <= (eq.size() > 1) ? W'(eq[1]) : '0;
    end
  end

  // Reference model: walks the string token by token with its own queue.
  int exp_op[$];
  int exp_in[$];
  int mq[$];
  int exp_err, exp_code;

  task automatic model_cmd(input int op, input int v);
    bit ok;
    ok = 1'b1;
    exp_op.push_back(op);
    exp_in.push_back(v);
    if (op == 5) begin
      if (mq.size() >= QDEPTH) ok = 1'b0;
      else mq.push_back(v);
    end else if (op == 6) begin
      if (mq.size() < 1) ok = 1'b0;
      else void'(mq.pop_front());
    end else begin
      if (mq.size() < 2) ok = 1'b0;
      else begin
        void'(mq.pop_front());
        void'(mq.pop_front());
        mq.push_front(v);
      end
    end
    if (!ok) begin
      exp_err  = 1;
      exp_code = 3;
    end
  endtask

  task automatic run_model(input string s);
    int acc, c, op, a, b, r;
    bit innum;
    exp_op.delete(); exp_in.delete(); mq.delete();
    exp_err = 0; exp_code = 0; acc = 0; innum = 1'b0;
    for (int i = 0; i < s.len(); i++) begin
      c = int'(s[i]);
      if (exp_err != 0) continue;
      op = -1;
      case (c)
        43: op = 0;
        45: op = 1;
        42: op = 2;
`ifdef CALC_DIV_EN
        47: op = 3;
        37: op = 4;
`endif
        100: op = 6;
        default: op = -1;
      endcase
      if (c >= 48 && c <= 57) begin
        a = innum ? acc * 10 + (c - 48) : (c - 48);
        if (a > 255) begin exp_err = 1; exp_code = 2; end
        else begin acc = a; innum = 1'b1; end
      end else if (c == 32 || c == 10) begin
        if (innum) begin model_cmd(5, acc); innum = 1'b0; end
      end else if (op >= 0) begin
        if (innum) begin model_cmd(5, acc); innum = 1'b0; end
        if (exp_err == 0) begin
          a = (mq.size() > 0) ? mq[0] : 0;
          b = (mq.size() > 1) ? mq[1] : 0;
          if ((op == 3 || op == 4) && b == 0) begin
            exp_err = 1; exp_code = 2;
          end else begin
            case (op)
              0: r = (a + b) % 256;
              1: r = (a - b + 256) % 256;
              2: r = (a * b) % 256;
              3: r = a / b;
              4: r = a % b;
              default: r = 0;
            endcase
            model_cmd(op, r);
          end
        end
      end else begin
        exp_err = 1; exp_code = 1;
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ch_valid = 1'b0;
    repeat (2) @(negedge clk);
    got_op.delete();
    got_in.delete();
    rst = 1'b0;
  endtask

  task automatic send_char(input logic [7:0] c, input int gap);
    bit done;
    done = 1'b0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    ch = c;
    ch_valid = 1'b1;
    for (int k = 0; k < 20 && !done; k++) begin
      if (ch_ready) begin
        @(posedge clk);
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    #1 ch_valid = 1'b0;
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: char %h not accepted, ch_ready %0b, required 1", c, ch_ready);
    end
  endtask

  task automatic run_str(input string s, input bit rnd_gap);
    do_reset();
    for (int i = 0; i < s.len(); i++)
      send_char(s[i], rnd_gap ? int'($urandom_range(0, 2)) : 0);
    repeat (12) @(negedge clk);
  endtask

  typedef struct {
    string s;
    int    napply;
    int    lop;
    int    lin;
    int    err;
    int    code;
  } vec_t;

  vec_t tbl[12];
  int ea[5];
  int er[5];
  int eo[5];
  int ei[5];

  initial begin
    string rs;
    int len, r;
    string alpha_op;
    string alpha_bad;
    alpha_op  = "+-*/%d";
    alpha_bad = "xa=";

    tbl[0]  = '{"12 7+\n", 3, 0, 19, 0, 0};
    tbl[1]  = '{"255 1+", 3, 0, 0, 0, 0};
    tbl[2]  = '{"3 5-", 3, 1, 254, 0, 0};
    tbl[3]  = '{"256", 0, 0, 0, 1, 2};
    tbl[4]  = '{"+", 1, 0, 0, 1, 3};
    tbl[5]  = '{"+5 ", 1, 0, 0, 1, 3};
    tbl[6]  = '{"x", 0, 0, 0, 1, 1};
    tbl[9]  = '{"6 4*d", 4, 6, 0, 0, 0};
    tbl[10] = '{"200 2*", 3, 2, 144, 0, 0};
`ifdef CALC_DIV_EN
    tbl[7]  = '{"9 0/", 2, 5, 0, 1, 2};
    tbl[8]  = '{"9 2/", 3, 3, 4, 0, 0};
    tbl[11] = '{"7 3%", 3, 4, 1, 0, 0};
`else
    tbl[7]  = '{"9 0/", 1, 5, 9, 1, 1};
    tbl[8]  = '{"9 2/", 1, 5, 9, 1, 1};
    tbl[11] = '{"7 3%", 1, 5, 7, 1, 1};
`endif

    #1;
    do_reset();
    @(negedge clk);
    chk("rst_apply", int'(q_apply), 0);
    chk("rst_op", int'(q_op), 0);
    chk("rst_in", int'(q_in), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_code", int'(err_code), 0);
    chk("rst_ready", int'(ch_ready), 1);

    // Cycle-exact push-then-operator sequence.
    ea = '{1, 0, 1, 0, 0};
    er = '{0, 0, 0, 0, 1};
    eo = '{5, 0, 0, 0, 0};
    ei = '{7, 0, 19, 0, 0};
    do_reset();
    send_char("1", 0); send_char("2", 0); send_char(" ", 0); send_char("7", 0);
    send_char("+", 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("tm%0d_apply", k), int'(q_apply), ea[k]);
      chk($sformatf("tm%0d_ready", k), int'(ch_ready), er[k]);
      if (ea[k] != 0) begin
        chk($sformatf("tm%0d_op", k), int'(q_op), eo[k]);
        chk($sformatf("tm%0d_in", k), int'(q_in), ei[k]);
      end
    end
    send_char(8'h0a, 0);
    repeat (4) @(negedge clk);
    chk("tm_napply", got_op.size(), 3);
    chk("tm_err", int'(err), 0);

    for (int i = 0; i < 12; i++) begin
      run_str(tbl[i].s, 1'b0);
      chk($sformatf("t%0d_napply", i), got_op.size(), tbl[i].napply);
      if (tbl[i].napply > 0) begin
        chk($sformatf("t%0d_lastop", i), (got_op.size() > 0) ? got_op[got_op.size()-1] : -1, tbl[i].lop);
        chk($sformatf("t%0d_lastin", i), (got_in.size() > 0) ? got_in[got_in.size()-1] : -1, tbl[i].lin);
      end
      chk($sformatf("t%0d_err", i), int'(err), tbl[i].err);
      chk($sformatf("t%0d_code", i), int'(err_code), tbl[i].code);
    end

    // Reset during SETTLE of the push that precedes an operator.
    do_reset();
    send_char("3", 0); send_char(" ", 0); send_char("4", 0); send_char("+", 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstmid_apply", int'(q_apply), 0);
    chk("rstmid_op", int'(q_op), 0);
    chk("rstmid_in", int'(q_in), 0);
    chk("rstmid_err", int'(err), 0);
    chk("rstmid_ready", int'(ch_ready), 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("rstmid_napply", got_op.size(), 2);

    for (int n = 0; n < 40; n++) begin
      rs = "";
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) begin
        r = $urandom_range(0, 99);
        if (r < 45)      rs = {rs, string'(8'(48 + $urandom_range(0, 9)))};
        else if (r < 55) rs = {rs, " "};
        else if (r < 60) rs = {rs, "\n"};
        else if (r < 95) rs = {rs, string'(alpha_op[$urandom_range(0, 5)])};
        else             rs = {rs, string'(alpha_bad[$urandom_range(0, 2)])};
      end
      run_model(rs);
      run_str(rs, 1'b1);
      chk($sformatf("r%0d_napply", n), got_op.size(), exp_op.size());
      for (int i = 0; i < exp_op.size() && i < got_op.size(); i++) begin
        chk($sformatf("r%0d_op%0d", n, i), got_op[i], exp_op[i]);
        chk($sformatf("r%0d_in%0d", n, i), got_in[i], exp_in[i]);
      end
      chk($sformatf("r%0d_err", n), int'(err), exp_err);
      chk($sformatf("r%0d_code", n), int'(err_code), exp_code);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
